// File: rtl/decode_stage.sv
// Decode stage: holds one fetched instruction, extracts fields and the immediate,
// reads the register file and stalls on load-use hazards against the execute stage.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  f_valid_i,
  output logic                  f_ready_o,
  input  logic [31:0]           instr_f_i,
  input  logic [XLEN-1:0]       pc_f_i,
  input  logic [XLEN-1:0]       pc_plus_4_f_i,
  input  logic                  flush_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [6:0]            op_o,
  output logic [2:0]            funct3_o,
  output logic [6:0]            funct7_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       rd1_o,
  output logic [XLEN-1:0]       rd2_o,
  output logic [XLEN-1:0]       imm_ext_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [XLEN-1:0]       pc_plus_4_o,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic [15:0]           hazard_cnt_o
);

  localparam int NREG = 2 ** REG_ADDR_W;

  function automatic logic [REG_ADDR_W-1:0] fit_addr(input logic [4:0] field);
    logic [REG_ADDR_W+4:0] wide;
    wide = {{REG_ADDR_W{1'b0}}, field};
    return wide[REG_ADDR_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  function automatic logic signed [31:0] imm_sel(input logic [31:0] ins);
    logic signed [31:0] imm;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {ins[31:12], 12'b0};
      7'b1101111:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  logic                  vld_p0;
  logic [31:0]           instr_p0;
  logic [XLEN-1:0]       pc_p0;
  logic [XLEN-1:0]       pc_plus_4_p0;
  logic [XLEN-1:0]       regs [NREG];
  logic [15:0]           hazard_cnt;
  logic                  hazard;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic signed [31:0]    imm32;

  // ---- stage p0: decode register ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p0       <= 1'b0;
      instr_p0     <= '0;
      pc_p0        <= '0;
      pc_plus_4_p0 <= '0;
    end else if (flush_i) begin
      vld_p0       <= 1'b0;
      instr_p0     <= '0;
      pc_p0        <= '0;
      pc_plus_4_p0 <= '0;
    end else if (f_ready_o) begin
      vld_p0 <= f_valid_i;
      if (f_valid_i) begin
        instr_p0     <= instr_f_i;
        pc_p0        <= pc_f_i;
        pc_plus_4_p0 <= pc_plus_4_f_i;
      end
    end
  end

  assign rs1 = fit_addr(instr_p0[19:15]);
  assign rs2 = fit_addr(instr_p0[24:20]);

  assign hazard    = vld_p0 && ex_load_i && (ex_rd_i != '0) &&
                     ((ex_rd_i == rs1) || (ex_rd_i == rs2));
  assign d_valid_o = vld_p0 && !hazard;
  assign f_ready_o = !vld_p0 || (d_ready_i && !hazard);

  assign op_o        = instr_p0[6:0];
  assign funct3_o    = instr_p0[14:12];
  assign funct7_o    = instr_p0[31:25];
  assign rs1_o       = rs1;
  assign rs2_o       = rs2;
  assign rd_o        = fit_addr(instr_p0[11:7]);
  assign pc_o        = pc_p0;
  assign pc_plus_4_o = pc_plus_4_p0;

  assign imm32     = imm_sel(instr_p0);
  assign imm_ext_o = XLEN'(imm32);

  // Register file: x0 is hardwired to zero, so writes to it are dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (rs1 != '0) begin
      if (BYPASS && wb_en_i && (wb_addr_i == rs1)) rd1_o = wb_data_i;
      else                                         rd1_o = regs[rs1];
    end
    if (rs2 != '0) begin
      if (BYPASS && wb_en_i && (wb_addr_i == rs2)) rd2_o = wb_data_i;
      else                                         rd2_o = regs[rs2];
    end
  end

  // Stall counter keeps counting through a flush cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     hazard_cnt <= '0;
    else if (hazard) hazard_cnt <= sat_inc(hazard_cnt);
  end

  assign hazard_cnt_o = hazard_cnt;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter REG_ADDR_W, 5, register address width; the register file holds 2**REG_ADDR_W entries.
REQ-003 SHALL have parameter BYPASS, 1, 1 = write-first read bypass, 0 = read returns the pre-write value.
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports f_valid_i in 1, f_ready_o out 1: fetch-side valid/ready handshake.
REQ-007 SHALL have ports instr_f_i in 32, pc_f_i in XLEN, pc_plus_4_f_i in XLEN: fetch payload.
REQ-008 SHALL have port flush_i  in  1  discard the held instruction.
REQ-009 SHALL have ports d_valid_o out 1, d_ready_i in 1: execute-side handshake.
REQ-010 SHALL have outputs op_o 7, funct3_o 3, funct7_o 7, rs1_o/rs2_o/rd_o REG_ADDR_W: decoded fields.
REQ-011 SHALL have outputs rd1_o XLEN, rd2_o XLEN, imm_ext_o XLEN, pc_o XLEN, pc_plus_4_o XLEN.
REQ-012 SHALL have inputs wb_en_i 1, wb_addr_i REG_ADDR_W, wb_data_i XLEN: writeback port.
REQ-013 SHALL have inputs ex_load_i 1, ex_rd_i REG_ADDR_W: a load currently in execute and its destination.
REQ-014 SHALL have output hazard_cnt_o 16: saturating count of load-use stall cycles.

Function
REQ-015 SHALL hold a decode register {valid_q, instr, pc, pc_plus_4}.
REQ-016 SHALL drive rs1/rs2/rd from instr[19:15], [24:20], [11:7], zero-extended or truncated to REG_ADDR_W.
REQ-017 SHALL assert hazard when valid_q, ex_load_i, ex_rd_i != 0, and ex_rd_i equals rs1 or rs2.
REQ-018 SHALL drive d_valid_o = valid_q && !hazard.
REQ-019 SHALL drive f_ready_o = !valid_q || (d_ready_i && !hazard).
REQ-020 SHALL, on a rising edge with flush_i = 1, clear valid_q and the payload to 0 regardless of other inputs; flush has the highest non-reset priority.
REQ-021 SHALL otherwise, when f_ready_o is 1, load f_valid_i into valid_q and capture the payload when f_valid_i = 1; otherwise it shall hold.
REQ-022 SHALL select the immediate combinationally from op, sign-extended to XLEN:
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011, with bit 0 = 0
  - U: 0110111, 0010111, as {instr[31:12], 12'b0}
  - J: 1101111, with bit 0 = 0
  - any other opcode: 0
REQ-023 SHALL implement the register file with two asynchronous reads and one synchronous write.
REQ-024 SHALL return 0 on reads of address 0 and ignore writes to address 0.
REQ-025 SHALL, with BYPASS = 1, return wb_data_i on a read when wb_en_i = 1 and wb_addr_i equals the nonzero read address.
REQ-026 SHALL increment hazard_cnt_o each cycle hazard = 1, saturating at 0xFFFF.
REQ-027 SHALL, in a cycle with both flush_i and hazard, still count that hazard cycle.
REQ-028 SHALL hold all outputs stable while d_valid_o = 1 and d_ready_i = 0.

Reset
REQ-029 SHALL, on reset_i asserted at any time, immediately clear valid_q, the payload, all registers and hazard_cnt_o to 0, giving d_valid_o = 0 and f_ready_o = 1.
REQ-030 SHALL drop an instruction in flight at reset with no partial output.

Verification
REQ-031 SHALL cover: reset, then write x5 = 0x1234 and present addi x6,x5,-1 (0xFFF28313) -> rd1_o = 0x1234, imm_ext_o = 0xFFFFFFFF, d_valid_o = 1.
REQ-032 SHALL cover: BYPASS = 1, wb_en_i with x7 = 0xA5A5A5A5 in the same cycle as decoding a read of x7 -> rd1_o = 0xA5A5A5A5; with BYPASS = 0 -> the old value.
REQ-033 SHALL cover: ex_load_i = 1, ex_rd_i = 6 with decoded rs2 = 6 for 3 cycles -> d_valid_o = 0, f_ready_o = 0 for those cycles, hazard_cnt_o = 3; then release -> the same instruction issues.
REQ-034 SHALL cover: d_ready_i = 0 for 4 cycles with valid held -> outputs stable; flush_i = 1 -> d_valid_o = 0 on the next cycle.
REQ-035 SHALL cover: a write to x0 of 0xFFFF, then a read of x0 -> 0; and a jal (0x0080006F) -> imm_ext_o = 8.
REQ-036 SHALL cover: reset_i asserted mid-stall -> d_valid_o = 0, hazard_cnt_o = 0, and all registers read 0 after release.
